joypad_serializer: RTL and testbench
====================================

// Module: joypad_serializer
// PURPOSE
//  Emulates one NES standard controller (CD4021-style 8-bit shift register) feeding the joypad port block.
//  Takes 8 raw active-high button levels (board switches / keyboard decoder), debounces them,
//  parallel-loads them while jp_latch is high and shifts one bit out per jp_clk access.
//  Drives the active-low serial line that the joypad port samples as jp1_data / jp2_data.
//  Instantiate once per player.
// PARAMETERS
//  DEBOUNCE_CYCLES  50000  consecutive clk cycles a synced button must differ from its stable value
//                          before the stable value flips; legal range >= 1
//  MASK_OPPOSING    1      1: Up+Down both pressed -> both reported released; same for Left+Right
//  SYNC_STAGES      2      flops in each input synchronizer (buttons_raw, jp_latch, jp_clk); >= 2
// PORTS
//  clk          in   1  system clock, same clock as the joypad port block
//  rst_n        in   1  asynchronous active-low reset
//  buttons_raw  in   8  raw buttons, 1 = pressed; [0]A [1]B [2]Select [3]Start [4]Up [5]Down [6]Left [7]Right
//  jp_latch     in   1  controller latch/strobe from the joypad port (bit 0 of writes to $4016)
//  jp_clk       in   1  controller clock from the joypad port, high for the duration of a $4016/$4017 read
//  jp_data      out  1  serial data, active-low: 0 = current bit is pressed
//  buttons_db   out  8  debounced, masked button state (same bit map), for debug LEDs
// BEHAVIOUR
//  Reset (async assert, sync-released flops)
//   - all synchronizers 0, debounce counters 0, stable state 0, shreg 8'h00
//   - jp_data = 1, buttons_db = 8'h00
//  Input sync
//   - each of buttons_raw[i], jp_latch, jp_clk passes through SYNC_STAGES flops -> *_s
//   - jp_clk_s is additionally registered to form jp_clk_q; fall = jp_clk_q & ~jp_clk_s
//   - jp_clk is combinational upstream and may glitch; only the synced version is used
//  Debounce, per bit i, independent
//   - if btn_s[i] == stable[i]: cnt[i] <= 0
//   - else if cnt[i] == DEBOUNCE_CYCLES-1: stable[i] <= btn_s[i], cnt[i] <= 0
//   - else: cnt[i] <= cnt[i]+1
//   - so stable flips exactly DEBOUNCE_CYCLES cycles after btn_s first differs
//   - any intervening match restarts the count
//   - counter width = $clog2(DEBOUNCE_CYCLES+1); counter never exceeds DEBOUNCE_CYCLES-1
//  Masking, combinational on stable, when MASK_OPPOSING=1
//   - masked[5:4] = 2'b00 if stable[5:4] == 2'b11
//   - masked[7:6] = 2'b00 if stable[7:6] == 2'b11
//   - otherwise masked = stable; buttons_db = masked
//  Shift register shreg[7:0], stores active-high pressed bits, priority order:
//   1. latch_s == 1: shreg <= masked every cycle (transparent load); falls of jp_clk are ignored
//   2. else if fall: shreg <= {1'b1, shreg[7:1]}
//      (fill with 1 -> reads after the 8th return "pressed", matching an official pad)
//   3. else hold
//  jp_data = ~shreg[0], a pure inversion of a flop (glitch-free)
//  Timing
//   - A is visible on jp_data SYNC_STAGES+1 cycles after jp_latch rises
//   - shift occurs SYNC_STAGES+1 cycles after jp_clk falls, i.e. after the read completes,
//     so the port samples the current bit during the read and the next bit appears before the next read
//  Boundary cases
//   - jp_clk high while latch high, then latch falls: no shift; the first shift needs a later fall
//   - more than 8 shifts: jp_data stays 0
//   - button change mid-read-sequence: shreg not affected until the next latch
//   - rst_n asserted mid-sequence: immediate return to reset values; jp_data = 1
// TESTING
//  1. Reset, DEBOUNCE_CYCLES=4, buttons_raw=8'h09 held, latch pulse, 8 jp_clk pulses
//     -> jp_data per read = 0,1,1,0,1,1,1,1 (A, Start pressed)
//  2. Continue with 4 more jp_clk pulses after test 1 -> jp_data = 0 on all 4 (fill ones)
//  3. DEBOUNCE_CYCLES=4: toggle buttons_raw[0] for 3 cycles then back
//     -> buttons_db[0] stays 0; hold 4+ cycles -> buttons_db[0]=1 exactly 4 cycles after btn_s changes
//  4. MASK_OPPOSING=1, buttons_raw=8'h30 (Up+Down) -> buttons_db=8'h00
//     buttons_raw=8'h50 (Up+Left) -> buttons_db=8'h50
//  5. jp_latch held high, buttons_raw 8'h01->8'h02, jp_clk pulses during latch
//     -> jp_data tracks bit0 (1 after debounce), no shifting; after latch low, first read = B state order
//  6. Assert rst_n low after 3 shifts -> jp_data=1, buttons_db=8'h00 asynchronously;
//     after release a new latch/8-read sequence reports correctly

Source files
------------

// File: rtl/joypad_serializer.sv
// NES standard controller emulation: synchronizes and debounces 8 raw buttons,
// masks opposing directions, and serializes them CD4021-style onto an active-low line.

module jp_debounce_bit #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_s,
    output logic stable
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [CW-1:0] cnt;

    // Any sample that matches the stable value restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            stable <= 1'b0;
        end else if (btn_s == stable) begin
            cnt <= '0;
        end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
            stable <= btn_s;
            cnt    <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end
endmodule

module joypad_serializer #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter bit MASK_OPPOSING   = 1'b1,
    parameter int SYNC_STAGES     = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] buttons_raw,
    input  logic       jp_latch,
    input  logic       jp_clk,
    output logic       jp_data,
    output logic [7:0] buttons_db
);
    logic [SYNC_STAGES-1:0][7:0] btn_sync;
    logic [SYNC_STAGES-1:0]      latch_sync;
    logic [SYNC_STAGES-1:0]      clk_sync;
    logic [7:0]                  btn_s;
    logic                        latch_s;
    logic                        jp_clk_s;
    logic                        jp_clk_q;
    logic                        clk_fall;
    logic [7:0]                  stable;
    logic [7:0]                  masked;
    logic [7:0]                  shreg;

    // Stage 0 takes the raw input; the top stage is the synchronized output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_sync   <= '0;
            latch_sync <= '0;
            clk_sync   <= '0;
            jp_clk_q   <= 1'b0;
        end else begin
            btn_sync   <= {btn_sync[SYNC_STAGES-2:0], buttons_raw};
            latch_sync <= {latch_sync[SYNC_STAGES-2:0], jp_latch};
            clk_sync   <= {clk_sync[SYNC_STAGES-2:0], jp_clk};
            jp_clk_q   <= jp_clk_s;
        end
    end

    assign btn_s    = btn_sync[SYNC_STAGES-1];
    assign latch_s  = latch_sync[SYNC_STAGES-1];
    assign jp_clk_s = clk_sync[SYNC_STAGES-1];
    assign clk_fall = jp_clk_q & ~jp_clk_s;

    for (genvar i = 0; i < 8; i++) begin : g_db
        jp_debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .clk   (clk),
            .rst_n (rst_n),
            .btn_s (btn_s[i]),
            .stable(stable[i])
        );
    end

    // A real pad can't report both directions of an axis at once.
    always_comb begin
        masked = stable;
        if (MASK_OPPOSING) begin
            if (stable[5:4] == 2'b11) masked[5:4] = 2'b00;
            if (stable[7:6] == 2'b11) masked[7:6] = 2'b00;
        end
    end

    assign buttons_db = masked;

    // Shifting in ones makes reads past the 8th return "pressed", like an official pad.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            shreg <= 8'h00;
        else if (latch_s)
            shreg <= masked;
        else if (clk_fall)
            shreg <= {1'b1, shreg[7:1]};
    end

    assign jp_data = ~shreg[0];
endmodule

// File: tb/tb_joypad_serializer.sv
// Scoreboard bench for joypad_serializer: the driver queues expected read bits and
// debounced states, independent monitors pop and compare them against the DUT.

module tb_joypad_serializer;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] buttons_raw;
    logic       jp_latch;
    logic       jp_clk;
    logic       jp_data;
    logic [7:0] buttons_db;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] exp;
        string      tag;
    } item_t;

    item_t rd_q[$];
    item_t db_q[$];

    joypad_serializer #(
        .DEBOUNCE_CYCLES(4),
        .MASK_OPPOSING  (1'b1),
        .SYNC_STAGES    (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .buttons_raw(buttons_raw),
        .jp_latch   (jp_latch),
        .jp_clk     (jp_clk),
        .jp_data    (jp_data),
        .buttons_db (buttons_db)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", tag, act, exp);
        end
    endtask

    // Reference: what an ideal pad reports for a given set of held buttons.
    function automatic logic [7:0] pad_state(input logic [7:0] p);
        logic [7:0] m = p;
        if (((p >> 4) & 8'd3) == 8'd3) m = m & 8'hCF;
        if (((p >> 6) & 8'd3) == 8'd3) m = m & 8'h3F;
        return m;
    endfunction

    // Read n (0-based) of a sequence: the button bit, inverted, then pressed forever.
    function automatic logic read_bit(input logic [7:0] state, input int n);
        if (n >= 8) return 1'b0;
        return ~state[n];
    endfunction

    // Read monitor: samples jp_data deep inside each jp_clk high window.
    int hi_cnt = 0;
    always @(negedge clk) begin
        item_t it;
        if (jp_clk === 1'b1) hi_cnt++;
        else hi_cnt = 0;
        if (hi_cnt == 3) begin
            if (rd_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_read actual=%b expected=none", jp_data);
            end else begin
                it = rd_q.pop_front();
                check(it.tag, {7'b0, jp_data}, it.exp);
            end
        end
    end

    // Debounced-state monitor.
    always @(negedge clk) begin
        item_t it;
        if (db_q.size() != 0) begin
            it = db_q.pop_front();
            check(it.tag, buttons_db, it.exp);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_db(input logic [7:0] e, input string tag);
        item_t it;
        it.exp = e;
        it.tag = tag;
        db_q.push_back(it);
    endtask

    task automatic do_read(input logic e, input string tag);
        item_t it;
        it.exp = {7'b0, e};
        it.tag = tag;
        rd_q.push_back(it);
        jp_clk = 1'b1;
        tick(4);
        jp_clk = 1'b0;
        tick(6);
    endtask

    task automatic do_latch();
        jp_latch = 1'b1;
        tick(6);
        jp_latch = 1'b0;
        tick(4);
    endtask

    task automatic settle(input logic [7:0] p);
        buttons_raw = p;
        tick(12);
    endtask

    logic [7:0] t1_exp;
    logic [7:0] st;

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n       = 1'b0;
        buttons_raw = 8'h00;
        jp_latch    = 1'b0;
        jp_clk      = 1'b0;
        tick(2);
        check("reset_jp_data", {7'b0, jp_data}, 8'h01);
        check("reset_buttons_db", buttons_db, 8'h00);
        rst_n = 1'b1;
        tick(2);

        // A and Start pressed: reads 0,1,1,0,1,1,1,1 then fill.
        settle(8'h09);
        expect_db(8'h09, "t1_db");
        tick(1);
        do_latch();
        t1_exp = 8'b1111_0110;
        for (int i = 0; i < 8; i++) do_read(t1_exp[i], $sformatf("t1_read%0d", i));
        for (int i = 0; i < 4; i++) do_read(1'b0, $sformatf("t2_fill%0d", i));

        // Debounce: 3-cycle glitch rejected, 4-cycle hold accepted on the exact cycle.
        settle(8'h00);
        buttons_raw = 8'h01;
        tick(3);
        buttons_raw = 8'h00;
        for (int i = 0; i < 8; i++) begin
            expect_db(8'h00, $sformatf("t3_glitch%0d", i));
            tick(1);
        end
        buttons_raw = 8'h01;
        tick(5);
        expect_db(8'h00, "t3_before_flip");
        tick(1);
        expect_db(8'h01, "t3_at_flip");
        tick(2);

        // Opposing directions.
        settle(8'h30);
        expect_db(8'h00, "t4_up_down");
        tick(1);
        settle(8'h50);
        expect_db(8'h50, "t4_up_left");
        tick(1);
        settle(8'hC0);
        expect_db(8'h00, "t4_left_right");
        tick(1);

        // Latch held: transparent load, jp_clk ignored.
        settle(8'h01);
        jp_latch = 1'b1;
        tick(6);
        do_read(1'b0, "t5_latch_a_pressed");
        do_read(1'b0, "t5_latch_no_shift");
        buttons_raw = 8'h02;
        tick(12);
        do_read(1'b1, "t5_latch_tracks");
        jp_latch = 1'b0;
        tick(4);
        for (int i = 0; i < 8; i++)
            do_read(read_bit(8'h02, i), $sformatf("t5_read%0d", i));

        // Reset mid-sequence.
        settle(8'h81);
        do_latch();
        for (int i = 0; i < 3; i++)
            do_read(read_bit(8'h81, i), $sformatf("t6_pre%0d", i));
        #3;
        rst_n = 1'b0;
        #1;
        check("t6_rst_jp_data", {7'b0, jp_data}, 8'h01);
        check("t6_rst_buttons_db", buttons_db, 8'h00);
        tick(2);
        rst_n = 1'b1;
        settle(8'h81);
        do_latch();
        for (int i = 0; i < 8; i++)
            do_read(read_bit(8'h81, i), $sformatf("t6_post%0d", i));

        // Random patterns, random sequence lengths, random mid-sequence changes.
        for (int it = 0; it < 20; it++) begin
            int nreads;
            settle(8'($urandom));
            st = pad_state(buttons_raw);
            expect_db(st, $sformatf("rnd%0d_db", it));
            tick(1);
            do_latch();
            nreads = 8 + int'($urandom_range(0, 4));
            for (int i = 0; i < nreads; i++) begin
                if (i == 2 && $urandom_range(0, 1) == 1) buttons_raw = 8'($urandom);
                do_read(read_bit(st, i), $sformatf("rnd%0d_read%0d", it, i));
            end
        end

        tick(4);
        if (rd_q.size() != 0 || db_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL queue_drain actual=%0d expected=0", rd_q.size() + db_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
